// File: rtl/reward_scheduler.sv
// reward_scheduler: arbitrates packet-pack triggers into single FBType requests.
// Define REWARD_TIMER_EN to build the shared MR/TS timeout timer.
module reward_scheduler #(
  parameter int WORD_WIDTH   = 16,
  parameter int MR_TIMEOUT   = 10,
  parameter int TS_TIMEOUT   = 10,
  parameter int MAX_INV_HOPS = 4
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic                  en,
  input  logic                  pktValid,
  input  logic [2:0]            fPacketType,
  input  logic [WORD_WIDTH-1:0] fHopsFromCH,
  input  logic                  iAmDestination,
  input  logic                  role,
  input  logic                  chElected,
  input  logic                  sendData,
  input  logic                  hbClear,
  input  logic                  reward_done,
  output logic                  reward_en,
  output logic [3:0]            FBType,
  output logic                  hbLock,
  output logic                  busy,
  output logic [WORD_WIDTH-1:0] timeout
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;

  logic [1:0] state;
  logic [6:0] pend;
  logic [6:0] pend_set;
  logic [6:0] pend_clr;
  logic [2:0] pick;
  logic [3:0] fb_q;
  logic       done_seen;
  logic       hb_trig;
  logic       inv_trig;
  logic       fin;
  logic       mr_exp;
  logic       ts_exp;

  assign hb_trig  = pktValid && (fPacketType == 3'b000) && !hbLock;
  assign inv_trig = pktValid && (fPacketType == 3'b010)
                 && (fHopsFromCH < WORD_WIDTH'(MAX_INV_HOPS));
  assign fin      = (state == S_WAIT) && (reward_done || done_seen);

`ifdef REWARD_TIMER_EN
  logic [WORD_WIDTH-1:0] tcnt;
  logic                  ttype;
  logic                  load_mr;
  logic                  load_ts;

  assign load_mr = inv_trig && !role;
  assign load_ts = fin && (fb_q == 4'd4);
  assign mr_exp  = en && (tcnt == WORD_WIDTH'(1)) && !ttype;
  assign ts_exp  = en && (tcnt == WORD_WIDTH'(1)) && ttype;
  assign timeout = tcnt;

  // A zero count means stopped; loads only land on a stopped timer.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      tcnt  <= '0;
      ttype <= 1'b0;
    end else if (tcnt == '0) begin
      if (load_mr) begin
        tcnt  <= WORD_WIDTH'(MR_TIMEOUT);
        ttype <= 1'b0;
      end else if (load_ts) begin
        tcnt  <= WORD_WIDTH'(TS_TIMEOUT);
        ttype <= 1'b1;
      end
    end else if (en) begin
      tcnt <= tcnt - WORD_WIDTH'(1);
    end
  end
`else
  logic unused_role;

  assign unused_role = role;
  assign mr_exp      = 1'b0;
  assign ts_exp      = 1'b0;
  assign timeout     = '0;
`endif

  assign pend_set = {
    sendData,
    ts_exp,
    chElected,
    pktValid && iAmDestination,
    mr_exp,
    inv_trig,
    hb_trig
  };

  always_comb begin
    pick = 3'd0;
    for (int i = 6; i >= 0; i--) begin
      if (pend[i]) pick = 3'(i);
    end
  end

  always_comb begin
    pend_clr = '0;
    if (state == S_IDLE && en && |pend) pend_clr[pick] = 1'b1;
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      pend   <= '0;
      hbLock <= 1'b0;
    end else begin
      pend <= (pend & ~pend_clr) | pend_set;
      if (hb_trig)      hbLock <= 1'b1;
      else if (hbClear) hbLock <= 1'b0;
    end
  end

  // A done seen during S_ISSUE is remembered so S_WAIT exits at once.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state     <= S_IDLE;
      fb_q      <= 4'd0;
      done_seen <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          done_seen <= 1'b0;
          if (en && |pend) begin
            fb_q  <= {1'b0, pick};
            state <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          done_seen <= reward_done;
          state     <= S_WAIT;
        end
        S_WAIT: begin
          if (fin) begin
            done_seen <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign reward_en = (state == S_ISSUE);
  assign busy      = (state != S_IDLE);
  assign FBType    = fb_q;

endmodule

// File: tb/tb_reward_scheduler.sv
// tb_reward_scheduler: directed checks of reward_scheduler.
// Timer expectations follow REWARD_TIMER_EN when it is defined.
module tb_reward_scheduler;

  logic        clk = 1'b0;
  logic        nrst;
  logic        en;
  logic        pktValid;
  logic [2:0]  fPacketType;
  logic [15:0] fHopsFromCH;
  logic        iAmDestination;
  logic        role;
  logic        chElected;
  logic        sendData;
  logic        hbClear;
  logic        reward_done;
  logic        reward_en;
  logic [3:0]  FBType;
  logic        hbLock;
  logic        busy;
  logic [15:0] timeout;

  int cyc = 0;
  int n_cmp = 0;
  int n_err = 0;

  reward_scheduler dut (
    .clk            (clk),
    .nrst           (nrst),
    .en             (en),
    .pktValid       (pktValid),
    .fPacketType    (fPacketType),
    .fHopsFromCH    (fHopsFromCH),
    .iAmDestination (iAmDestination),
    .role           (role),
    .chElected      (chElected),
    .sendData       (sendData),
    .hbClear        (hbClear),
    .reward_done    (reward_done),
    .reward_en      (reward_en),
    .FBType         (FBType),
    .hbLock         (hbLock),
    .busy           (busy),
    .timeout        (timeout)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pkt(input logic [2:0] ty, input logic [15:0] hops,
                     input logic dest, output int c);
    pktValid       = 1'b1;
    fPacketType    = ty;
    fHopsFromCH    = hops;
    iAmDestination = dest;
    c = cyc;
    tick();
    pktValid       = 1'b0;
    iAmDestination = 1'b0;
  endtask

  task automatic serve(input logic [3:0] fb, input string tag,
                       output int t);
    int n;
    n = 0;
    while (!reward_en && n < 40) begin
      tick();
      n++;
    end
    chk({tag, "_issue"}, 32'(reward_en), 1);
    chk({tag, "_fb"}, 32'(FBType), 32'(fb));
    t = cyc;
    reward_done = 1'b1;
    tick();
    reward_done = 1'b0;
  endtask

  task automatic no_issue(input string tag, input int n);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < n; i++) begin
      tick();
      if (reward_en) seen = 1'b1;
    end
    chk(tag, 32'(seen), 0);
  endtask

  initial begin
    int c, c2, t, t3, t4, t6, t5, d;
    logic bad;
    nrst = 1'b0; en = 1'b1; pktValid = 1'b0; fPacketType = 3'd0;
    fHopsFromCH = '0; iAmDestination = 1'b0; role = 1'b1;
    chElected = 1'b0; sendData = 1'b0; hbClear = 1'b0;
    reward_done = 1'b0;
    repeat (3) tick();
    chk("rst_en", 32'(reward_en), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_hblock", 32'(hbLock), 0);
    chk("rst_fb", 32'(FBType), 0);
    chk("rst_timeout", 32'(timeout), 0);
    nrst = 1'b1;
    tick();

    // heartbeat lock
    pkt(3'b000, 16'd0, 1'b0, c);
    chk("hb_lock", 32'(hbLock), 1);
    chk("hb_early", 32'(reward_en), 0);
    serve(4'd0, "hb", t);
    chk("hb_lat", 32'(t - c), 2);
    chk("hb_wait_busy", 32'(busy), 1);
    tick();
    chk("hb_idle", 32'(busy), 0);
    pkt(3'b000, 16'd0, 1'b0, c);
    no_issue("hb_dup", 6);
    hbClear = 1'b1;
    tick();
    hbClear = 1'b0;
    chk("hb_clear", 32'(hbLock), 0);
    pkt(3'b000, 16'd0, 1'b0, c);
    serve(4'd0, "hb3", t);
    tick();

    hbClear = 1'b1;
    pkt(3'b000, 16'd0, 1'b0, c);
    hbClear = 1'b0;
    chk("hb_clr_locked", 32'(hbLock), 0);
    no_issue("hb_clr_noreq", 4);
    hbClear = 1'b1;
    pkt(3'b000, 16'd0, 1'b0, c);
    hbClear = 1'b0;
    chk("hb_race_lock", 32'(hbLock), 1);
    serve(4'd0, "hb_race", t);
    tick();

    // INV ripple, no timer for a CH
    role = 1'b0;
    pkt(3'b010, 16'd4, 1'b0, c);
    no_issue("inv4", 5);
    chk("inv4_tmr", 32'(timeout), 0);
    role = 1'b1;
    pkt(3'b010, 16'd3, 1'b0, c);
    serve(4'd1, "inv3", t);
    chk("inv3_tmr", 32'(timeout), 0);
    tick();

    // priority and CH flow
    sendData = 1'b1; chElected = 1'b1;
    pkt(3'b011, 16'd9, 1'b1, c);
    sendData = 1'b0; chElected = 1'b0;
    serve(4'd3, "pri3", t3);
    chk("pri_lat", 32'(t3 - c), 2);
    serve(4'd4, "pri4", t4);
    chk("pri_gap4", 32'(t4 - t3), 3);
    serve(4'd6, "pri6", t6);
    chk("pri_gap6", 32'(t6 - t4), 3);
`ifdef REWARD_TIMER_EN
    chk("ts_count", 32'(timeout), 8);
    serve(4'd5, "ts", t5);
    chk("ts_lat", 32'(t5 - t4), 13);
`else
    chk("ts_count", 32'(timeout), 0);
    no_issue("no_ts", 20);
`endif
    tick();

    // MR timer, second load ignored
    role = 1'b0;
    pkt(3'b010, 16'd3, 1'b0, c);
    serve(4'd1, "mr_inv", t);
`ifdef REWARD_TIMER_EN
    chk("mr_count", 32'(timeout), 8);
`else
    chk("mr_count", 32'(timeout), 0);
`endif
    tick();
    pkt(3'b010, 16'd2, 1'b0, c2);
    serve(4'd1, "mr_inv2", t);
`ifdef REWARD_TIMER_EN
    serve(4'd2, "mr", t);
    chk("mr_lat", 32'(t - c), 12);
    repeat (4) tick();
    chk("mr_stop", 32'(timeout), 0);
`else
    no_issue("no_mr", 20);
`endif
    role = 1'b1;
    tick();

    // stall with a trigger queued
    sendData = 1'b1;
    tick();
    sendData = 1'b0;
    tick();
    chk("stall_issue", 32'(reward_en), 1);
    bad = 1'b0;
    pkt(3'b011, 16'd9, 1'b1, c);
    for (int i = 0; i < 19; i++) begin
      if (!busy || FBType != 4'd6 || reward_en) bad = 1'b1;
      tick();
    end
    chk("stall_stable", 32'(bad), 0);
    chk("stall_busy", 32'(busy), 1);
    reward_done = 1'b1;
    d = cyc;
    tick();
    reward_done = 1'b0;
    chk("stall_idle", 32'(busy), 0);
    tick();
    chk("stall_reissue", 32'(reward_en), 1);
    chk("stall_fb", 32'(FBType), 3);
    chk("stall_lat", 32'(cyc - d), 2);
    reward_done = 1'b1;
    tick();
    reward_done = 1'b0;
    tick();

    // en low while waiting, retriggers coalesce
    sendData = 1'b1;
    tick();
    sendData = 1'b0;
    tick();
    chk("en_issue", 32'(reward_en), 1);
    en = 1'b0;
    tick();
    sendData = 1'b1;
    tick();
    tick();
    sendData = 1'b0;
    reward_done = 1'b1;
    tick();
    reward_done = 1'b0;
    chk("en_done_idle", 32'(busy), 0);
    no_issue("en_low", 5);
    en = 1'b1;
    c = cyc;
    serve(4'd6, "en_high", t);
    chk("en_lat", 32'(t - c), 1);
    no_issue("coalesce", 6);

    // set and clear colliding on one bit
    sendData = 1'b1;
    tick();
    tick();
    sendData = 1'b0;
    serve(4'd6, "coll1", t);
    serve(4'd6, "coll2", t3);
    chk("coll_gap", 32'(t3 - t), 3);
    no_issue("coll_once", 6);

    // reset in S_WAIT with the MR timer running
    role = 1'b0;
    chk("pre_rst_lock", 32'(hbLock), 1);
    pkt(3'b010, 16'd1, 1'b0, c);
    repeat (4) tick();
    chk("pre_rst_busy", 32'(busy), 1);
`ifdef REWARD_TIMER_EN
    chk("pre_rst_tmr", 32'(timeout), 6);
`else
    chk("pre_rst_tmr", 32'(timeout), 0);
`endif
    nrst = 1'b0;
    #1;
    chk("mid_rst_en", 32'(reward_en), 0);
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_lock", 32'(hbLock), 0);
    chk("mid_rst_fb", 32'(FBType), 0);
    chk("mid_rst_tmr", 32'(timeout), 0);
    tick();
    nrst = 1'b1;
    no_issue("post_rst", 20);
    chk("post_rst_busy", 32'(busy), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
